rca_seq_ctrl: RTL

RCA_SEQ_CTRL -- requirements
Module: rca_seq_ctrl

---
 rtl/rca_pkg.sv | 16 +
 rtl/ripple_carry_adder.sv | 28 ++
 rtl/rca_seq_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/rca_pkg.sv
// Shared definitions for the sequential ripple-carry adder controller.
//   rca_state_t : controller state encoding (IDLE / ADD / DONE)
//   DEF_SIZE    : default chunk width in bits
//   DEF_CHUNKS  : default number of chunks per operand
package rca_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } rca_state_t;

    localparam int DEF_SIZE   = 4;
    localparam int DEF_CHUNKS = 4;

endpackage

// File: rtl/ripple_carry_adder.sv
// Plain SIZE-bit ripple-carry adder built from a chain of full adders.
// Ports:
//   a, b : SIZE-bit addends
//   cin  : carry into bit 0
//   s    : SIZE-bit sum
//   co   : carry out of the most significant bit
module ripple_carry_adder #(
    parameter int SIZE = 4
) (
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    input  logic            cin,
    output logic [SIZE-1:0] s,
    output logic            co
);

    logic [SIZE:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < SIZE; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co = c[SIZE];

endmodule

// File: rtl/rca_seq_ctrl.sv
// Sequential multi-chunk adder: one shared SIZE-bit ripple-carry slice is
// reused over CHUNKS cycles to form a W = SIZE*CHUNKS bit sum.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   start_valid  : request an addition            (in)
//   start_ready  : controller can accept a request (out)
//   A, B, Cin    : operands, captured on acceptance
//   res_valid    : S/Cout hold a finished result   (out)
//   res_ready    : consumer takes the result       (in)
//   S, Cout      : W-bit sum and final carry
//   busy         : operation in progress or result pending
//   dbg_state    : current controller state (rca_state_t encoding)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. start_ready is high only in IDLE, so a request is accepted on the
// first edge with start_valid=1 while idle; requests at other times are
// dropped, not queued. res_valid stays high with S/Cout stable until an edge
// with res_ready=1; res_ready has no effect while res_valid is low.
// Every output comes straight from a register.
module rca_seq_ctrl
    import rca_pkg::*;
#(
    parameter int SIZE   = DEF_SIZE,
    parameter int CHUNKS = DEF_CHUNKS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic [SIZE*CHUNKS-1:0] A,
    input  logic [SIZE*CHUNKS-1:0] B,
    input  logic                 Cin,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [SIZE*CHUNKS-1:0] S,
    output logic                 Cout,
    output logic                 busy,
    output logic [1:0]           dbg_state
);

    localparam int W    = SIZE * CHUNKS;
    // Keep at least one index bit so CHUNKS=1 still builds.
    localparam int IDXW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(CHUNKS - 1);

    rca_state_t      state;
    logic [IDXW-1:0] idx;
    logic            carry;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic [W-1:0]    s_reg;
    logic            cout_reg;

    logic [SIZE-1:0] slice_a;
    logic [SIZE-1:0] slice_b;
    logic [SIZE-1:0] slice_s;
    logic            slice_co;

    // Chunk selection for the shared slice; idx only advances in ADD.
    assign slice_a = a_reg[idx*SIZE +: SIZE];
    assign slice_b = b_reg[idx*SIZE +: SIZE];

    ripple_carry_adder #(
        .SIZE (SIZE)
    ) u_slice (
        .a   (slice_a),
        .b   (slice_b),
        .cin (carry),
        .s   (slice_s),
        .co  (slice_co)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            carry       <= 1'b0;
            a_reg       <= '0;
            b_reg       <= '0;
            s_reg       <= '0;
            cout_reg    <= 1'b0;
            res_valid   <= 1'b0;
            busy        <= 1'b0;
            start_ready <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        a_reg       <= A;
                        b_reg       <= B;
                        carry       <= Cin;
                        idx         <= '0;
                        state       <= ADD;
                        start_ready <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                ADD: begin
                    // Partial sum chunks land in S as they are produced.
                    s_reg[idx*SIZE +: SIZE] <= slice_s;
                    carry                   <= slice_co;
                    if (idx == LAST_IDX) begin
                        cout_reg  <= slice_co;
                        res_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx + IDXW'(1);
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid   <= 1'b0;
                        busy        <= 1'b0;
                        start_ready <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    res_valid   <= 1'b0;
                    busy        <= 1'b0;
                    start_ready <= 1'b1;
                end
            endcase
        end
    end

    assign S         = s_reg;
    assign Cout      = cout_reg;
    assign dbg_state = state;

endmodule
